// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle EXE-stage ALU with valid/ready handshakes and flush cancel
// Define ALU_MC_DIV_EN to build the iterative radix-2 divider; otherwise div ops return 0 in one cycle.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cancel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [18:0]      alu_op,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result
);
  localparam int SHW = $clog2(WIDTH);

`ifdef ALU_MC_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_BUSY = 2'd2} state_t;
`else
  typedef enum logic {S_IDLE = 1'b0, S_DONE = 1'b1} state_t;
`endif

  state_t state, state_nxt, start_state;

  logic               accept;
  logic               div_req;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   mulhu_res;
  logic [WIDTH-1:0]   sra_res;
  logic [WIDTH-1:0]   short_res;
  logic               res_load;
  logic [WIDTH-1:0]   res_val;

  assign div_req = |alu_op[18:15];
  assign accept  = in_valid & in_ready & ~cancel;
  assign shamt   = alu_src2[SHW-1:0];
  assign sra_res = $unsigned($signed(alu_src1) >>> shamt);

  // One signed multiplier; the unsigned high half is corrected from it using the operand signs.
  assign prod_s    = {{WIDTH{alu_src1[WIDTH-1]}}, alu_src1} * {{WIDTH{alu_src2[WIDTH-1]}}, alu_src2};
  assign mulhu_res = prod_s[2*WIDTH-1:WIDTH]
                   + (alu_src1[WIDTH-1] ? alu_src2 : '0)
                   + (alu_src2[WIDTH-1] ? alu_src1 : '0);

  always_comb begin
    short_res = '0;
    if (alu_op[0])  short_res = short_res | (alu_src1 + alu_src2);
    if (alu_op[1])  short_res = short_res | (alu_src1 - alu_src2);
    if (alu_op[2])  short_res = short_res | {{(WIDTH-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
    if (alu_op[3])  short_res = short_res | {{(WIDTH-1){1'b0}}, alu_src1 < alu_src2};
    if (alu_op[4])  short_res = short_res | (alu_src1 & alu_src2);
    if (alu_op[5])  short_res = short_res | ~(alu_src1 | alu_src2);
    if (alu_op[6])  short_res = short_res | (alu_src1 | alu_src2);
    if (alu_op[7])  short_res = short_res | (alu_src1 ^ alu_src2);
    if (alu_op[8])  short_res = short_res | (alu_src1 << shamt);
    if (alu_op[9])  short_res = short_res | (alu_src1 >> shamt);
    if (alu_op[10]) short_res = short_res | sra_res;
    if (alu_op[11]) short_res = short_res | alu_src2;
    if (alu_op[12]) short_res = short_res | prod_s[WIDTH-1:0];
    if (alu_op[13]) short_res = short_res | prod_s[2*WIDTH-1:WIDTH];
    if (alu_op[14]) short_res = short_res | mulhu_res;
  end

`ifdef ALU_MC_DIV_EN
  logic [WIDTH-1:0] div_quo, div_rem, div_dvsr;
  logic [SHW-1:0]   div_cnt;
  logic             div_neg_q, div_neg_r, div_want_rem, div_zero;
  logic             div_signed, div_rem_sel, div_last;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] quo_nxt, rem_nxt, quo_fin, rem_fin, div_res;

  // Lowest-numbered div bit wins: 15 div, 16 mod, 17 divu, 18 modu.
  assign div_signed  = alu_op[15] | alu_op[16];
  assign div_rem_sel = ~alu_op[15] & (alu_op[16] | (~alu_op[17] & alu_op[18]));
  assign mag1 = (div_signed & alu_src1[WIDTH-1]) ? -alu_src1 : alu_src1;
  assign mag2 = (div_signed & alu_src2[WIDTH-1]) ? -alu_src2 : alu_src2;

  // Restoring step: quotient bits shift in from the bottom as dividend bits shift out of the top.
  assign div_shift = {div_rem, div_quo[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, div_dvsr};
  assign rem_nxt   = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign quo_nxt   = {div_quo[WIDTH-2:0], ~div_diff[WIDTH+1]};
  assign div_last  = (state == S_BUSY) && (div_cnt == SHW'(WIDTH-1));

  // With a zero divisor the loop leaves |src1| in the remainder, so only the quotient needs forcing.
  assign quo_fin = div_zero ? '1 : (div_neg_q ? -quo_nxt : quo_nxt);
  assign rem_fin = div_neg_r ? -rem_nxt : rem_nxt;
  assign div_res = div_want_rem ? rem_fin : quo_fin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || cancel) begin
      div_quo      <= '0;
      div_rem      <= '0;
      div_dvsr     <= '0;
      div_cnt      <= '0;
      div_neg_q    <= 1'b0;
      div_neg_r    <= 1'b0;
      div_want_rem <= 1'b0;
      div_zero     <= 1'b0;
    end else if (accept && div_req) begin
      div_quo      <= mag1;
      div_rem      <= '0;
      div_dvsr     <= mag2;
      div_cnt      <= '0;
      div_neg_q    <= div_signed & (alu_src1[WIDTH-1] ^ alu_src2[WIDTH-1]);
      div_neg_r    <= div_signed & alu_src1[WIDTH-1];
      div_want_rem <= div_rem_sel;
      div_zero     <= (alu_src2 == '0);
    end else if (state == S_BUSY) begin
      div_quo <= quo_nxt;
      div_rem <= rem_nxt;
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign start_state = div_req ? S_BUSY : S_DONE;
  assign res_load    = (accept & ~div_req) | (div_last & ~cancel);
  assign res_val     = div_last ? div_res : short_res;
`else
  assign start_state = S_DONE;
  assign res_load    = accept;
  assign res_val     = div_req ? '0 : short_res;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) state_nxt = start_state;
        S_DONE: if (out_ready) state_nxt = accept ? start_state : S_IDLE;
`ifdef ALU_MC_DIV_EN
        S_BUSY: if (div_last) state_nxt = S_DONE;
`endif
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~cancel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         alu_result <= '0;
    else if (res_load) alu_result <= res_val;
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc (WIDTH=32), both ALU_MC_DIV_EN builds
module tb_alu_mc;
  localparam int W = 32;
`ifdef ALU_MC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int DIV_LAT = DIV_EN ? W + 1 : 1;

  logic         clk = 1'b0;
  logic         reset, cancel, in_valid, in_ready, out_valid, out_ready;
  logic [18:0]  alu_op;
  logic [W-1:0] alu_src1, alu_src2, alu_result;
  int vectors = 0;
  int miscompares = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .cancel(cancel), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] oh(input int i);
    logic [18:0] v;
    v = 19'd1 << i;
    return v;
  endfunction

  // Behavioural reference: plain 64-bit integer arithmetic, no iteration.
  function automatic logic [W-1:0] ref_model(input logic [18:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    longint sa, sb, ps;
    longint unsigned pu;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    if (op[18:15] != 4'd0) begin
      if (!DIV_EN) return '0;
      if (op[15] || op[16]) begin
        if (b == '0) return op[15] ? '1 : a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[15] ? a : '0;
        return op[15] ? W'(sa / sb) : W'(sa % sb);
      end
      if (b == '0) return op[17] ? '1 : a;
      return op[17] ? a / b : a % b;
    end
    ps = sa * sb;
    pu = longint'(unsigned'(a)) * longint'(unsigned'(b));
    r = '0;
    if (op[0])  r = r | (a + b);
    if (op[1])  r = r | (a - b);
    if (op[2])  r = r | {31'd0, sa < sb};
    if (op[3])  r = r | {31'd0, a < b};
    if (op[4])  r = r | (a & b);
    if (op[5])  r = r | ~(a | b);
    if (op[6])  r = r | (a | b);
    if (op[7])  r = r | (a ^ b);
    if (op[8])  r = r | (a << sh);
    if (op[9])  r = r | (a >> sh);
    if (op[10]) r = r | W'(sa >>> sh);
    if (op[11]) r = r | b;
    if (op[12]) r = r | W'(ps);
    if (op[13]) r = r | W'(ps >>> 32);
    if (op[14]) r = r | W'(pu >> 32);
    return r;
  endfunction

  function automatic int ref_lat(input logic [18:0] op);
    return (op[18:15] != 4'd0) ? DIV_LAT : 1;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return W'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  // Drives one op from IDLE; returns result, cycles to out_valid and whether it held through a stall.
  task automatic run_op(input logic [18:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, output logic [W-1:0] res, output int lat, output bit stable);
    @(negedge clk);
    alu_op = op; alu_src1 = a; alu_src2 = b; in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = alu_result;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || alu_result !== res || in_ready !== 1'b0) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; cancel = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; alu_src1 = '0; alu_src2 = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_result !== '0) begin
      miscompares++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h, want 1 0 0", in_ready, out_valid, alu_result);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    alu_op = oh(0); alu_src1 = 32'h7FFF_FFFF; alu_src2 = 32'h1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || alu_result !== 32'h8000_0000 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL add_overflow: valid=%b result=%h in_ready=%b, want 1 80000000 1", out_valid, alu_result, in_ready);
    end
    alu_op = oh(3); alu_src1 = 32'h1; alu_src2 = 32'h2;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || alu_result !== 32'h1) begin
      miscompares++;
      $display("FAIL b2b_sltu: valid=%b result=%h, want 1 00000001", out_valid, alu_result);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_div();
    logic [18:0]  ops [10];
    logic [W-1:0] as [10], bs [10], exps [10];
    logic [W-1:0] res;
    int lat;
    bit st;
    ops = '{oh(15), oh(16), oh(17), oh(18), oh(15), oh(16), oh(15), oh(16), oh(0) | oh(17), oh(16) | oh(17)};
    as  = '{-32'sd7, -32'sd7, 32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd9, -32'sd5, 32'd7, -32'sd7};
    bs  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd2, 32'd2};
    exps = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0, 32'd3,
             32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFF};
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], as[i], bs[i], 0, res, lat, st);
      vectors++;
      if (res !== (DIV_EN ? exps[i] : 32'd0) || lat != DIV_LAT) begin
        miscompares++;
        $display("FAIL div_case%0d: result=%h lat=%0d, want %h lat=%0d", i, res, lat,
                 DIV_EN ? exps[i] : 32'd0, DIV_LAT);
      end
    end
  endtask

  task automatic test_mul_mix();
    logic [18:0]  ops [6];
    logic [W-1:0] as [6], bs [6], exps [6];
    logic [W-1:0] res;
    int lat;
    bit st;
    ops  = '{oh(13), oh(14), oh(12), oh(0) | oh(7), 19'd0, oh(11)};
    as   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd123, 32'd9};
    bs   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd456, 32'hABCD_0000};
    exps = '{32'h0, 32'hFFFF_FFFE, 32'h1, 32'hE, 32'h0, 32'hABCD_0000};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], 0, res, lat, st);
      vectors++;
      if (res !== exps[i] || lat != 1) begin
        miscompares++;
        $display("FAIL mul_mix%0d: result=%h lat=%0d, want %h lat=1", i, res, lat, exps[i]);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    alu_op = oh(10); alu_src1 = 32'h8000_0000; alu_src2 = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || alu_result !== 32'hF800_0000 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL sra_hold%0d: valid=%b result=%h in_ready=%b, want 1 f8000000 0", i, out_valid, alu_result, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL sra_release: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_cancel();
    logic [W-1:0] res;
    int lat, seen;
    bit st;
    @(negedge clk);
    alu_op = oh(17); alu_src1 = 32'd100; alu_src2 = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    alu_op = oh(0); alu_src1 = 32'd1; alu_src2 = 32'd1; in_valid = 1'b1; cancel = 1'b1;
    #1;
    vectors++;
    if (in_ready !== !DIV_EN) begin
      miscompares++;
      $display("FAIL cancel_in_ready: in_ready=%b, want %b", in_ready, !DIV_EN);
    end
    @(negedge clk);
    cancel = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cancel_next: valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL cancel_quiet: out_valid seen %0d cycles, want 0", seen);
    end
    run_op(oh(0), 32'd3, 32'd4, 0, res, lat, st);
    vectors++;
    if (res !== 32'd7 || lat != 1) begin
      miscompares++;
      $display("FAIL cancel_then_add: result=%h lat=%0d, want 00000007 lat=1", res, lat);
    end
    // Cancel while a result is held drops it.
    @(negedge clk);
    alu_op = oh(0); alu_src1 = 32'd1; alu_src2 = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0; out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cancel_done: valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    alu_op = oh(0); alu_src1 = 32'd3; alu_src2 = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || alu_result !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset_done: valid=%b result=%h in_ready=%b, want 0 0 1", out_valid, alu_result, in_ready);
    end
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    alu_op = oh(6); alu_src1 = 32'h50; alu_src2 = 32'h05; in_valid = 1'b1;
    @(negedge clk);
    alu_op = oh(15); alu_src1 = 32'd100; alu_src2 = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || alu_result !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset_busy: valid=%b result=%h in_ready=%b, want 0 0 1", out_valid, alu_result, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [18:0]  op;
    logic [W-1:0] a, b, res;
    int lat, hold;
    bit st;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0:       op = '0;
        1, 2:    op = 19'($urandom);
        default: op = oh($urandom_range(0, 18));
      endcase
      a = rand_operand();
      b = rand_operand();
      hold = $urandom_range(0, 3);
      run_op(op, a, b, hold, res, lat, st);
      vectors++;
      if (res !== ref_model(op, a, b) || lat != ref_lat(op) || !st) begin
        miscompares++;
        $display("FAIL random%0d op=%h a=%h b=%h: result=%h lat=%0d held=%b, want %h lat=%0d held=1",
                 n, op, a, b, res, lat, st, ref_model(op, a, b), ref_lat(op));
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_div();
    test_mul_mix();
    test_hold();
    test_cancel();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
